fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin burst arbiter that shares one sync_fifo write port between NUM_SRC producers.
- Each producer uses a valid/ready handshake.
- The arbiter grants one source at a time for a burst of up to MAX_BURST words and tags every word with its source id.
- It sits directly in front of sync_fifo and drives its wdata_valid, write_data and flush inputs.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
SRC_ID_WIDTH, 2, width of source id tag; must equal clog2(NUM_SRC)
DATA_WIDTH, 16, payload width per source
MAX_BURST, 4, maximum words accepted per grant (1..255)
BEAT_CNT_WIDTH, 3, width of the beat counter; must hold MAX_BURST-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
src_valid  in  NUM_SRC  per-source word valid
src_data  in  NUM_SRC*DATA_WIDTH  flattened payloads, source i at [i*DATA_WIDTH +: DATA_WIDTH]
src_ready  out  NUM_SRC  per-source accept; a word transfers when valid and ready are both high
flush_req  in  1  abort request; forwarded to FIFO
fifo_full  in  1  from sync_fifo
fifo_afull  in  1  from sync_fifo
fifo_wdata_valid  out  1  write strobe to sync_fifo
fifo_write_data  out  SRC_ID_WIDTH+DATA_WIDTH  {grant_id, payload}
fifo_flush  out  1  flush to sync_fifo
grant_id  out  SRC_ID_WIDTH  currently granted source
busy  out  1  high while in BURST

Behaviour:
- Reset state:
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0.
  - All outputs are 0 in the cycle following reset assertion.
  - Reset mid-burst drops the burst with no further accepts.
- State machine:
  - Two states, IDLE and BURST.
  - state, grant_id, rr_ptr and beat_cnt are registered.
- IDLE:
  - If flush_req=0, fifo_afull=0 and any src_valid is high: select the first valid source searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - Register it into grant_id, clear beat_cnt, go to BURST next cycle.
  - If fifo_afull=1, stay in IDLE. No new burst starts while the FIFO is almost full.
- Combinational outputs in BURST:
  - accept = src_valid[grant_id] & ~fifo_full.
  - src_ready[grant_id] = ~fifo_full. All other ready bits are 0.
  - fifo_wdata_valid = accept.
  - fifo_write_data = {grant_id, src_data of grant_id}.
- BURST transitions, in priority order:
  1. flush_req=1: go to IDLE, rr_ptr unchanged, no accept that cycle (ready and valid forced 0).
  2. accept with beat_cnt==MAX_BURST-1: go to IDLE, rr_ptr = grant_id+1 mod NUM_SRC.
  3. src_valid[grant_id]=0: go to IDLE, rr_ptr = grant_id+1 mod NUM_SRC. A zero-beat burst is legal.
  4. accept: beat_cnt+1.
  5. Otherwise (fifo_full stall): hold everything. fifo_afull does not end a running burst.
- Latency:
  - First word of a burst transfers at the earliest one cycle after valid is seen in IDLE.
  - Every burst ends with at least one IDLE cycle before the next grant.
- In IDLE, src_ready=0 and fifo_wdata_valid=0.
- fifo_flush = flush_req, combinational pass-through.
- busy = (state==BURST).
- rr_ptr wraps from NUM_SRC-1 to 0.
- beat_cnt never exceeds MAX_BURST-1.

Decomposition:
- Shared package fifo_arb_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_BURST=1'b1.
  - SRC_ID_WIDTH derivation function.
- Sub-module rr_pick:
  - Combinational round-robin first-one finder.
  - Inputs: request vector and rr_ptr. Outputs: any_req and index.
- The top level holds the FSM, counters and datapath mux.

Test Plan:
1. Only src0 valid with 6 words 0x0001..0x0006, FIFO never full: 4 writes tagged 0 (0x00001..0x00004), busy drops, 1 IDLE cycle, then 2 writes (0x00005, 0x00006).
2. All 4 sources continuously valid, MAX_BURST=4: grant_id sequence 0,1,2,3,0, each burst exactly 4 beats; FIFO word count per source is equal after 32 writes.
3. src1 in BURST after 2 beats, fifo_full held for 3 cycles: src_ready and fifo_wdata_valid are 0 for those 3 cycles, beat_cnt holds; burst resumes and ends after 4 total beats with no lost or duplicated data.
4. fifo_afull=1 in IDLE with src2 valid: no grant while afull is high; grant to 2 one cycle after afull falls. afull rising mid-burst does not shorten the burst.
5. flush_req pulsed during beat 2 of src3: fifo_flush is high the same cycle with no write that cycle; next cycle IDLE, rr_ptr still 3, so src3 is granted again first.
6. reset asserted mid-burst for 1 cycle: the next cycle shows all outputs 0, rr_ptr=0; after release, a src0/src2 contention grants src0 first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared definitions for the FIFO write-port arbiter
//
// Holds the FSM state encoding and the helper that derives the source-id
// tag width from the number of sources. Imported by rr_pick and
// fifo_write_arbiter.

package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_BURST = ST_BURST
  } arb_state_e;

  // Bits needed to tag a word with its source index; at least one bit so
  // the tag field never collapses to zero width.
  function automatic int src_id_width(input int num_src);
    int w;
    w = 0;
    while ((1 << w) < num_src) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-one finder
//
// Searches the request vector starting at ptr and wrapping modulo N,
// returning the first requesting index.
//
// Ports:
//   req      in   N  request vector
//   ptr      in   W  index searched first
//   any_req  out  1  at least one request bit is set
//   idx      out  W  first requesting index at or after ptr (0 when none)

module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any_req,
  output logic [W-1:0] idx
);

  int k;

  always_comb begin
    any_req = 1'b0;
    idx     = '0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any_req && req[k]) begin
        any_req = 1'b1;
        idx     = W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter for one sync_fifo write port
//
// Grants one producer at a time for a burst of up to MAX_BURST words and
// tags every word written to the FIFO with its source id.
//
// Ports:
//   clk               in   1                      system clock, rising edge
//   reset             in   1                      synchronous active-high reset
//   src_valid         in   NUM_SRC                per-source word valid
//   src_data          in   NUM_SRC*DATA_WIDTH     source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready         out  NUM_SRC                per-source accept
//   flush_req         in   1                      abort request, forwarded to FIFO
//   fifo_full         in   1                      FIFO full
//   fifo_afull        in   1                      FIFO almost full
//   fifo_wdata_valid  out  1                      FIFO write strobe
//   fifo_write_data   out  SRC_ID_WIDTH+DATA_WIDTH {grant_id, payload}
//   fifo_flush        out  1                      FIFO flush
//   grant_id          out  SRC_ID_WIDTH           currently granted source
//   busy              out  1                      burst in progress

module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int SRC_ID_WIDTH   = src_id_width(NUM_SRC),
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_BURST      = 4,
  parameter int BEAT_CNT_WIDTH = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_SRC-1:0]                 src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_data,
  output logic [NUM_SRC-1:0]                 src_ready,
  input  logic                               flush_req,
  input  logic                               fifo_full,
  input  logic                               fifo_afull,
  output logic                               fifo_wdata_valid,
  output logic [SRC_ID_WIDTH+DATA_WIDTH-1:0] fifo_write_data,
  output logic                               fifo_flush,
  output logic [SRC_ID_WIDTH-1:0]            grant_id,
  output logic                               busy
);

  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT   = BEAT_CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [SRC_ID_WIDTH-1:0]   LAST_SRC_ID = SRC_ID_WIDTH'(NUM_SRC - 1);

  arb_state_e                state_q, state_d;
  logic [SRC_ID_WIDTH-1:0]   grant_q, grant_d;
  logic [SRC_ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_q, beat_d;

  logic                      pick_any;
  logic [SRC_ID_WIDTH-1:0]   pick_idx;
  logic                      sel_valid;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      accept;
  logic [SRC_ID_WIDTH-1:0]   grant_next;

  rr_pick #(
    .N (NUM_SRC),
    .W (SRC_ID_WIDTH)
  ) u_rr_pick (
    .req     (src_valid),
    .ptr     (rr_ptr_q),
    .any_req (pick_any),
    .idx     (pick_idx)
  );

  assign sel_valid  = src_valid[grant_q];
  assign sel_data   = src_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  // Reset is folded in so a burst interrupted by reset takes no word in
  // the reset cycle itself.
  assign accept     = sel_valid & ~fifo_full & ~reset;
  assign grant_next = (grant_q == LAST_SRC_ID) ? '0 : grant_q + 1'b1;

  assign fifo_flush = flush_req;
  assign grant_id   = grant_q;
  assign busy       = (state_q == S_BURST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_ptr_d         = rr_ptr_q;
    beat_d           = beat_q;
    src_ready        = '0;
    fifo_wdata_valid = 1'b0;
    fifo_write_data  = '0;

    case (state_q)
      S_IDLE: begin
        // Almost-full only blocks new grants; it never cuts a running burst.
        if (!flush_req && !fifo_afull && pick_any) begin
          state_d = S_BURST;
          grant_d = pick_idx;
          beat_d  = '0;
        end
      end

      S_BURST: begin
        fifo_write_data = {grant_q, sel_data};
        if (flush_req) begin
          // Aborted burst keeps rr_ptr so the same source is retried first.
          state_d = S_IDLE;
        end else begin
          src_ready[grant_q] = ~fifo_full & ~reset;
          fifo_wdata_valid   = accept;
          if (accept && (beat_q == LAST_BEAT)) begin
            state_d  = S_IDLE;
            rr_ptr_d = grant_next;
          end else if (!sel_valid) begin
            state_d  = S_IDLE;
            rr_ptr_d = grant_next;
          end else if (accept) begin
            beat_d = beat_q + 1'b1;
          end
          // Otherwise the FIFO is full: hold count, grant and state.
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter

module tb_fifo_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  src_valid;
  logic [63:0] src_data;
  logic [3:0]  src_ready;
  logic        flush_req;
  logic        fifo_full;
  logic        fifo_afull;
  logic        fifo_wdata_valid;
  logic [17:0] fifo_write_data;
  logic        fifo_flush;
  logic [1:0]  grant_id;
  logic        busy;

  fifo_write_arbiter #(
    .NUM_SRC        (4),
    .SRC_ID_WIDTH   (2),
    .DATA_WIDTH     (16),
    .MAX_BURST      (4),
    .BEAT_CNT_WIDTH (3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .src_valid        (src_valid),
    .src_data         (src_data),
    .src_ready        (src_ready),
    .flush_req        (flush_req),
    .fifo_full        (fifo_full),
    .fifo_afull       (fifo_afull),
    .fifo_wdata_valid (fifo_wdata_valid),
    .fifo_write_data  (fifo_write_data),
    .fifo_flush       (fifo_flush),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic        fl;
    logic        full;
    logic        af;
    logic [63:0] d;
    logic        chk;
    logic [3:0]  e_rdy;
    logic        e_wv;
    logic [17:0] e_wd;
    logic        e_wdchk;
    logic        e_fl;
    logic [1:0]  e_gnt;
    logic        e_busy;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] cur_d [4];
  int          n_vec;
  int          n_miss;

  task automatic row(input logic rst, input logic [3:0] v, input logic fl,
                     input logic full, input logic af, input logic chk,
                     input logic [3:0] e_rdy, input logic e_wv,
                     input logic [17:0] e_wd, input logic e_wdchk,
                     input logic e_fl, input logic [1:0] e_gnt,
                     input logic e_busy);
    vec_t r;
    r.rst = rst; r.v = v; r.fl = fl; r.full = full; r.af = af;
    r.d = {cur_d[3], cur_d[2], cur_d[1], cur_d[0]};
    r.chk = chk; r.e_rdy = e_rdy; r.e_wv = e_wv; r.e_wd = e_wd;
    r.e_wdchk = e_wdchk; r.e_fl = e_fl; r.e_gnt = e_gnt; r.e_busy = e_busy;
    vq.push_back(r);
  endtask

  task automatic idl(input logic [3:0] v, input logic fl, input logic af,
                     input logic [1:0] gnt);
    row(1'b0, v, fl, 1'b0, af, 1'b1, 4'b0, 1'b0, 18'h0, 1'b0, fl, gnt, 1'b0);
  endtask

  task automatic wr(input logic [3:0] v, input logic af, input logic [1:0] gnt,
                    input logic [17:0] wd);
    row(1'b0, v, 1'b0, 1'b0, af, 1'b1, 4'(1 << gnt), 1'b1, wd, 1'b1, 1'b0, gnt, 1'b1);
  endtask

  task automatic rst_row();
    row(1'b1, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 18'h0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    int          wc;
    int          beats;
    int          cnt [4];
    logic        prev_busy;
    logic [1:0]  exp_src;
    logic [17:0] exp_wd;
    int          gq[$];
    logic        bad;

    n_vec = 0; n_miss = 0;
    for (int i = 0; i < 4; i++) cur_d[i] = 16'h0;
    reset = 1'b1; src_valid = '0; src_data = '0;
    flush_req = 1'b0; fifo_full = 1'b0; fifo_afull = 1'b0;

    // Reset state
    rst_row();
    row(0, 4'b0000, 0, 0, 0, 1, 4'b0, 0, 18'h0, 1, 0, 2'd0, 0);

    // Only src0 valid, six words: 4-beat burst, 1 idle, 2-beat burst
    cur_d[0] = 16'h0001; idl(4'b0001, 0, 0, 2'd0);
    wr(4'b0001, 0, 2'd0, 18'h00001);
    cur_d[0] = 16'h0002; wr(4'b0001, 0, 2'd0, 18'h00002);
    cur_d[0] = 16'h0003; wr(4'b0001, 0, 2'd0, 18'h00003);
    cur_d[0] = 16'h0004; wr(4'b0001, 0, 2'd0, 18'h00004);
    cur_d[0] = 16'h0005; idl(4'b0001, 0, 0, 2'd0);
    wr(4'b0001, 0, 2'd0, 18'h00005);
    cur_d[0] = 16'h0006; wr(4'b0001, 0, 2'd0, 18'h00006);
    row(0, 4'b0000, 0, 0, 0, 1, 4'b0001, 0, 18'h0, 0, 0, 2'd0, 1);
    idl(4'b0000, 0, 0, 2'd0);

    // src1 burst stalled 3 cycles by fifo_full after 2 beats
    rst_row();
    cur_d[1] = 16'h0101; idl(4'b0010, 0, 0, 2'd0);
    wr(4'b0010, 0, 2'd1, 18'h10101);
    cur_d[1] = 16'h0102; wr(4'b0010, 0, 2'd1, 18'h10102);
    cur_d[1] = 16'h0103;
    for (int i = 0; i < 3; i++)
      row(0, 4'b0010, 0, 1, 0, 1, 4'b0, 0, 18'h0, 0, 0, 2'd1, 1);
    wr(4'b0010, 0, 2'd1, 18'h10103);
    cur_d[1] = 16'h0104; wr(4'b0010, 0, 2'd1, 18'h10104);
    idl(4'b0000, 0, 0, 2'd1);

    // afull blocks a new grant to src2 but not a running burst
    cur_d[2] = 16'h0201;
    for (int i = 0; i < 3; i++) idl(4'b0100, 0, 1, 2'd1);
    idl(4'b0100, 0, 0, 2'd1);
    wr(4'b0100, 0, 2'd2, 18'h20201);
    cur_d[2] = 16'h0202; wr(4'b0100, 1, 2'd2, 18'h20202);
    cur_d[2] = 16'h0203; wr(4'b0100, 1, 2'd2, 18'h20203);
    cur_d[2] = 16'h0204; wr(4'b0100, 1, 2'd2, 18'h20204);
    idl(4'b0000, 0, 1, 2'd2);
    idl(4'b0000, 0, 0, 2'd2);

    // flush on beat 2 of src3: no write, rr_ptr kept so src3 wins over src0
    cur_d[3] = 16'h0301; idl(4'b1000, 0, 0, 2'd2);
    wr(4'b1000, 0, 2'd3, 18'h30301);
    cur_d[3] = 16'h0302;
    row(0, 4'b1000, 1, 0, 0, 1, 4'b0, 0, 18'h0, 0, 1, 2'd3, 1);
    cur_d[0] = 16'h0001; idl(4'b1001, 0, 0, 2'd3);
    wr(4'b1001, 0, 2'd3, 18'h30302);
    row(0, 4'b0000, 0, 0, 0, 1, 4'b1000, 0, 18'h0, 0, 0, 2'd3, 1);
    idl(4'b0000, 1, 0, 2'd3);

    // reset mid-burst of src2 (rr_ptr=2): after reset src0 beats src2
    cur_d[1] = 16'h0111; idl(4'b0010, 0, 0, 2'd3);
    wr(4'b0010, 0, 2'd1, 18'h10111);
    row(0, 4'b0000, 0, 0, 0, 1, 4'b0010, 0, 18'h0, 0, 0, 2'd1, 1);
    cur_d[2] = 16'h0221; idl(4'b0100, 0, 0, 2'd1);
    wr(4'b0100, 0, 2'd2, 18'h20221);
    cur_d[2] = 16'h0222;
    row(1, 4'b0100, 0, 0, 0, 1, 4'b0, 0, 18'h0, 0, 0, 2'd2, 1);
    cur_d[0] = 16'h0031;
    row(0, 4'b0101, 0, 0, 0, 1, 4'b0, 0, 18'h0, 1, 0, 2'd0, 0);
    wr(4'b0101, 0, 2'd0, 18'h00031);
    row(0, 4'b0000, 0, 0, 0, 1, 4'b0001, 0, 18'h0, 0, 0, 2'd0, 1);
    idl(4'b0000, 0, 0, 2'd0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = vq[i].rst; src_valid = vq[i].v; flush_req = vq[i].fl;
      fifo_full = vq[i].full; fifo_afull = vq[i].af; src_data = vq[i].d;
      #1;
      if (vq[i].chk) begin
        n_vec++;
        bad = (src_ready !== vq[i].e_rdy) || (fifo_wdata_valid !== vq[i].e_wv) ||
              (fifo_flush !== vq[i].e_fl) || (grant_id !== vq[i].e_gnt) ||
              (busy !== vq[i].e_busy) ||
              (vq[i].e_wdchk && (fifo_write_data !== vq[i].e_wd));
        if (bad) begin
          n_miss++;
          $display("FAIL vec%0d: got rdy=%b wv=%b wd=%h fl=%b gnt=%0d busy=%b, want rdy=%b wv=%b wd=%h(chk=%b) fl=%b gnt=%0d busy=%b",
                   i, src_ready, fifo_wdata_valid, fifo_write_data, fifo_flush, grant_id, busy,
                   vq[i].e_rdy, vq[i].e_wv, vq[i].e_wd, vq[i].e_wdchk, vq[i].e_fl, vq[i].e_gnt, vq[i].e_busy);
        end
      end
    end

    // All four sources continuously valid: fair 4-beat bursts, 32 writes
    @(negedge clk);
    reset = 1'b1; src_valid = 4'b0; flush_req = 1'b0; fifo_full = 1'b0; fifo_afull = 1'b0;
    @(negedge clk);
    reset = 1'b0; src_valid = 4'b1111;
    src_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    wc = 0; beats = 0; prev_busy = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 100 && wc < 32; c++) begin
      #1;
      if (busy && !prev_busy) gq.push_back(int'(grant_id));
      if (!busy && prev_busy) begin
        n_vec++;
        if (beats != 4) begin
          n_miss++;
          $display("FAIL burst_len: got %0d beats, want 4", beats);
        end
        beats = 0;
      end
      if (fifo_wdata_valid) begin
        exp_src = 2'((wc / 4) % 4);
        exp_wd  = {exp_src, 16'hA000 + 16'(exp_src)};
        n_vec++;
        if (fifo_write_data !== exp_wd) begin
          n_miss++;
          $display("FAIL rr_word%0d: got %h, want %h", wc, fifo_write_data, exp_wd);
        end
        cnt[fifo_write_data[17:16]]++;
        wc++;
        beats++;
      end
      prev_busy = busy;
      @(negedge clk);
    end
    n_vec++;
    if (wc < 32) begin
      n_miss++;
      $display("FAIL rr_timeout: got %0d writes, want 32", wc);
    end
    for (int s = 0; s < 4; s++) begin
      n_vec++;
      if (cnt[s] != 8) begin
        n_miss++;
        $display("FAIL rr_count src%0d: got %0d, want 8", s, cnt[s]);
      end
    end
    for (int b = 0; b < 5; b++) begin
      n_vec++;
      if (b >= gq.size()) begin
        n_miss++;
        $display("FAIL grant_seq[%0d]: got none, want %0d", b, b % 4);
      end else if (gq[b] != b % 4) begin
        n_miss++;
        $display("FAIL grant_seq[%0d]: got %0d, want %0d", b, gq[b], b % 4);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
